// File: rtl/regs_pkg.sv
// rtl/regs_pkg.sv - shared types and sizes for the picoMIPS register file and its loader
package regs_pkg;

    localparam int REG_ADDR_W = 3;
    localparam int NUM_REGS   = 6;

    typedef enum logic [2:0] {
        LOAD_X,
        WR_X,
        REL_X,
        LOAD_Y,
        WR_Y,
        REL_Y,
        RUN,
        SHOW
    } loader_state_t;

endpackage

// File: rtl/go_sync.sv
// rtl/go_sync.sv - sw_go synchronizer and edge detector, optional debounce under DEBOUNCE_EN
module go_sync #(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic n_reset,
    input  logic sw_go,
    output logic go_level,
    output logic go_rise
);

    logic sync1;
    logic sync2;
    logic edge_q;

    if (DB_CYCLES < 1) begin : g_bad_cfg
        $error("go_sync: DB_CYCLES must be at least 1");
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= sw_go;
            sync2 <= sync1;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [CW-1:0] db_cnt;
    logic          db_level;

    // Any sample that agrees with the current debounced level restarts the run.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            db_cnt   <= '0;
            db_level <= 1'b0;
        end else if (sync2 == db_level) begin
            db_cnt <= '0;
        end else if (db_cnt == CNT_LAST) begin
            db_cnt   <= '0;
            db_level <= sync2;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    assign go_level = db_level;
`else
    assign go_level = sync2;
`endif

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            edge_q <= 1'b0;
        end else begin
            edge_q <= go_level;
        end
    end

    assign go_rise = go_level & ~edge_q;

endmodule

// File: rtl/reg_loader.sv
// rtl/reg_loader.sv - switch-driven operand loader for the picoMIPS register file (DEBOUNCE_EN adds go debounce)
module reg_loader
    import regs_pkg::*;
#(
    parameter int                    n         = 8,
    parameter logic [REG_ADDR_W-1:0] X_ADDR    = 3'd1,
    parameter logic [REG_ADDR_W-1:0] Y_ADDR    = 3'd3,
    parameter int                    DB_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic [n-1:0]          sw_data,
    input  logic                  sw_go,
    input  logic                  done_in,
    output logic                  we,
    output logic [REG_ADDR_W-1:0] waddr,
    output logic [n-1:0]          wdata,
    output logic                  cpu_run,
    output logic                  ready_led
);

    loader_state_t state;
    loader_state_t state_nxt;
    logic          go_level;
    logic          go_rise;
    logic          go_low;

    if (X_ADDR == '0 || Y_ADDR == '0 || X_ADDR == Y_ADDR ||
        int'(X_ADDR) >= NUM_REGS || int'(Y_ADDR) >= NUM_REGS) begin : g_bad_cfg
        $error("reg_loader: X_ADDR/Y_ADDR must be distinct, nonzero and below NUM_REGS");
    end

    go_sync #(
        .DB_CYCLES(DB_CYCLES)
    ) u_go_sync (
        .clk      (clk),
        .n_reset  (n_reset),
        .sw_go    (sw_go),
        .go_level (go_level),
        .go_rise  (go_rise)
    );

    assign go_low = ~go_level;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state <= LOAD_X;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            LOAD_X: if (go_rise) state_nxt = WR_X;
            WR_X:   state_nxt = REL_X;
            REL_X:  if (go_low) state_nxt = LOAD_Y;
            LOAD_Y: if (go_rise) state_nxt = WR_Y;
            WR_Y:   state_nxt = REL_Y;
            REL_Y:  if (go_low) state_nxt = RUN;
            RUN:    if (done_in) state_nxt = SHOW;
            SHOW:   if (go_rise) state_nxt = LOAD_X;
            default: state_nxt = LOAD_X;
        endcase
    end

    // we is decoded from state only, so an async reset removes it at once.
    always_comb begin
        we        = 1'b0;
        cpu_run   = 1'b0;
        ready_led = 1'b0;
        unique case (state)
            LOAD_X, LOAD_Y: ready_led = 1'b1;
            WR_X, WR_Y:     we        = 1'b1;
            RUN:            cpu_run   = 1'b1;
            default: ;
        endcase
    end

    // Operands are taken straight from the switches; the operator holds them while sw_go is high.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            waddr <= '0;
            wdata <= '0;
        end else if (state == LOAD_X && go_rise) begin
            waddr <= X_ADDR;
            wdata <= sw_data;
        end else if (state == LOAD_Y && go_rise) begin
            waddr <= Y_ADDR;
            wdata <= sw_data;
        end
    end

endmodule

// File: tb/tb_reg_loader.sv
// tb/tb_reg_loader.sv - directed self-checking bench for reg_loader
module tb_reg_loader;

    logic       clk;
    logic       n_reset;
    logic [7:0] sw_data;
    logic       sw_go;
    logic       done_in;
    logic       we;
    logic [2:0] waddr;
    logic [7:0] wdata;
    logic       cpu_run;
    logic       ready_led;

    int total = 0;
    int bad   = 0;
    int we_seen;

    reg_loader dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .sw_data   (sw_data),
        .sw_go     (sw_go),
        .done_in   (done_in),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .cpu_run   (cpu_run),
        .ready_led (ready_led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (we) we_seen++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Full handshake: rise at edge k, write cycle between k+2 and k+3, release after.
    task automatic handshake(input string tag, input logic [7:0] d, input logic [2:0] exp_addr,
                             input logic exp_ready, input logic exp_run);
        sw_data = d;
        sw_go   = 1'b1;
        we_seen = 0;
        ticks(2);
        check({tag, "_we_early"}, we, 0);
        tick();
        check({tag, "_we"}, we, 1);
        check({tag, "_waddr"}, waddr, exp_addr);
        check({tag, "_wdata"}, wdata, d);
        check({tag, "_ready_wr"}, ready_led, 0);
        tick();
        check({tag, "_we_off"}, we, 0);
        ticks(6);
        check({tag, "_one_write"}, we_seen, 1);
        sw_go = 1'b0;
        ticks(2);
        check({tag, "_ready_rel"}, ready_led, 0);
        check({tag, "_run_rel"}, cpu_run, 0);
        tick();
        check({tag, "_ready_after"}, ready_led, exp_ready);
        check({tag, "_run_after"}, cpu_run, exp_run);
        check({tag, "_we_after"}, we, 0);
    endtask

    initial begin
        n_reset = 1'b0;
        sw_data = 8'h00;
        sw_go   = 1'b0;
        done_in = 1'b0;
        we_seen = 0;
        ticks(2);
        check("rst_we", we, 0);
        check("rst_waddr", waddr, 0);
        check("rst_wdata", wdata, 0);
        check("rst_cpu_run", cpu_run, 0);
        check("rst_ready", ready_led, 1);
        n_reset = 1'b1;
        ticks(2);

        handshake("x1", 8'h05, 3'd1, 1'b1, 1'b0);
        handshake("y1", 8'hFB, 3'd3, 1'b0, 1'b1);

        we_seen = 0;
        ticks(7);
        check("run_hold", cpu_run, 1);
        check("run_no_we", we_seen, 0);
        done_in = 1'b1;
        tick();
        check("show_run", cpu_run, 0);
        check("show_ready", ready_led, 0);
        done_in = 1'b0;

        // A rise in SHOW returns to LOAD_X without capturing.
        sw_data = 8'h3C;
        sw_go   = 1'b1;
        we_seen = 0;
        ticks(2);
        check("show_still", ready_led, 0);
        tick();
        check("back_ready", ready_led, 1);
        ticks(3);
        check("back_no_we", we_seen, 0);
        check("back_wdata", wdata, 8'hFB);
        check("back_waddr", waddr, 3'd3);
        sw_go = 1'b0;
        ticks(3);

        // done_in outside RUN must not leave LOAD_X.
        done_in = 1'b1;
        ticks(2);
        check("done_ignored", ready_led, 1);
        done_in = 1'b0;

        // A one-cycle low in REL_X is a release; the next rise captures y1.
        sw_data = 8'h7E;
        sw_go   = 1'b1;
        ticks(3);
        check("b_we_x", we, 1);
        check("b_wdata_x", wdata, 8'h7E);
        sw_go = 1'b0;
        tick();
        sw_go   = 1'b1;
        sw_data = 8'h81;
        tick();
        check("b_rel", ready_led, 0);
        tick();
        check("b_load_y", ready_led, 1);
        tick();
        check("b_we_y", we, 1);
        check("b_waddr_y", waddr, 3'd3);
        check("b_wdata_y", wdata, 8'h81);

        // Reset in the WR_Y cycle takes effect without a clock edge.
        n_reset = 1'b0;
        #1;
        check("mid_rst_we", we, 0);
        check("mid_rst_run", cpu_run, 0);
        check("mid_rst_ready", ready_led, 1);
        check("mid_rst_waddr", waddr, 0);
        sw_go = 1'b0;
        ticks(2);
        n_reset = 1'b1;
        ticks(2);

        handshake("x1b", 8'h12, 3'd1, 1'b1, 1'b0);
        handshake("y1b", 8'h80, 3'd3, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
